iob_bus_arbiter2: RTL and testbench



---
 rtl/iob_bus_arbiter2.sv | 107 ++++++++++
 tb/tb_iob_bus_arbiter2.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_bus_arbiter2.sv
// Two-master / one-slave arbiter for the native iob bus (ibus = master 0, dbus = master 1).
// Define IOB_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to master 1.
module iob_bus_arbiter2 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter int RESP_W = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REQ_W-1:0]  m0_req,
  output logic [RESP_W-1:0] m0_resp,
  input  logic [REQ_W-1:0]  m1_req,
  output logic [RESP_W-1:0] m1_resp,
  output logic [REQ_W-1:0]  s_req,
  input  logic [RESP_W-1:0] s_resp,
  output logic              grant,
  output logic              busy
);

  // Handshake: a request is {valid, addr, wdata, wstrb}; the master holds it
  // stable until it sees a one-cycle ready (s_resp[0]) routed back to it.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             grant_d;
  logic             m0_valid;
  logic             m1_valid;
  logic             winner;
  logic [REQ_W-1:0] sel_req;
  logic             sel_valid;
  logic             s_ready;

  assign m0_valid  = m0_req[REQ_W-1];
  assign m1_valid  = m1_req[REQ_W-1];
  assign sel_req   = grant ? m1_req : m0_req;
  assign sel_valid = sel_req[REQ_W-1];
  assign s_ready   = s_resp[0];
  assign busy      = (state_q == GRANT);

`ifdef IOB_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On contention the master that was not served last wins.
  assign winner = (m0_valid && m1_valid) ? ~last_q : m1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == GRANT && sel_valid && s_ready) begin
      last_q <= grant;
    end
  end
`else
  assign winner = m1_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
    end
  end

  // Slave request is only ever driven from the registered grant, never from
  // a master valid directly, so arbitration costs exactly one cycle.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    s_req   = '0;
    m0_resp = '0;
    m1_resp = '0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (sel_valid) begin
          s_req = sel_req;
          if (grant) begin
            m1_resp = s_resp;
          end else begin
            m0_resp = s_resp;
          end
          if (s_ready) begin
            state_d = IDLE;
          end
        end else begin
          // Granted master withdrew its request: abandon without updating history.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_bus_arbiter2.sv
// Self-checking bench for iob_bus_arbiter2: slave model, two master drivers and an
// expected-transaction scoreboard; expected grant order follows IOB_ARB_ROUND_ROBIN_EN.
module tb_iob_bus_arbiter2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 1;
  localparam int PAY_W  = REQ_W - 1;
  localparam int EXP_W  = 1 + PAY_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [REQ_W-1:0]  m0_req;
  logic [REQ_W-1:0]  m1_req;
  logic [REQ_W-1:0]  s_req;
  logic [RESP_W-1:0] m0_resp;
  logic [RESP_W-1:0] m1_resp;
  logic [RESP_W-1:0] s_resp;
  logic              grant;
  logic              busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Expected entry: {master, addr, wdata, wstrb, rdata}
  logic [EXP_W-1:0] exp_q[$];
  logic [PAY_W-1:0] m0_q[$];
  logic [PAY_W-1:0] m1_q[$];
  logic             rdy0_s;
  logic             rdy1_s;

  int               sl_wait;
  int               sl_cnt;
  logic [DATA_W-1:0] sl_rdata;

  iob_bus_arbiter2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .m0_req  (m0_req),
    .m0_resp (m0_resp),
    .m1_req  (m1_req),
    .m1_resp (m1_resp),
    .s_req   (s_req),
    .s_resp  (s_resp),
    .grant   (grant),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Slave answers sl_wait cycles after first seeing valid.
  always @(posedge clk or posedge rst) begin
    if (rst) sl_cnt <= 0;
    else if (s_req[REQ_W-1] && !s_resp[0]) sl_cnt <= sl_cnt + 1;
    else sl_cnt <= 0;
  end
  assign s_resp = (s_req[REQ_W-1] && sl_cnt == sl_wait) ? {sl_rdata, 1'b1} : '0;

  function automatic logic [PAY_W-1:0] make_pay(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d,
                                                input logic [STRB_W-1:0] s);
    return {a, d, s};
  endfunction

  // One clock: scoreboard at negedge, then masters advance after the posedge.
  task automatic tick();
    logic [EXP_W-1:0]  e;
    logic [RESP_W-1:0] x0;
    logic [RESP_W-1:0] x1;
    @(negedge clk);
    rdy0_s = m0_resp[0];
    rdy1_s = m1_resp[0];
    if (!rst && s_req[REQ_W-1] && s_resp[0]) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got grant=%0d req=%h, want no transaction", grant, s_req);
      end else begin
        e = exp_q.pop_front();
        if ({grant, s_req[PAY_W-1:0]} !== e[EXP_W-1:DATA_W]) begin
          n_fail++;
          $display("FAIL sb_req: got %h, want %h", {grant, s_req[PAY_W-1:0]}, e[EXP_W-1:DATA_W]);
        end
        x0 = e[EXP_W-1] ? '0 : {e[DATA_W-1:0], 1'b1};
        x1 = e[EXP_W-1] ? {e[DATA_W-1:0], 1'b1} : '0;
        n_cmp++;
        if ({m0_resp, m1_resp} !== {x0, x1}) begin
          n_fail++;
          $display("FAIL sb_resp: got m0=%h m1=%h, want m0=%h m1=%h", m0_resp, m1_resp, x0, x1);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rdy0_s || !m0_req[REQ_W-1]) begin
      if (m0_q.size() > 0) m0_req = {1'b1, m0_q.pop_front()};
      else m0_req = '0;
    end
    if (rdy1_s || !m1_req[REQ_W-1]) begin
      if (m1_q.size() > 0) m1_req = {1'b1, m1_q.pop_front()};
      else m1_req = '0;
    end
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m0_q.size() != 0 || m1_q.size() != 0 ||
            m0_req[REQ_W-1] || m1_req[REQ_W-1] || busy) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending busy=%0d, want 0 pending busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic apply_reset();
    rst    = 1'b1;
    m0_req = '0;
    m1_req = '0;
    m0_q.delete();
    m1_q.delete();
    exp_q.delete();
    rdy0_s   = 1'b0;
    rdy1_s   = 1'b0;
    sl_wait  = 0;
    sl_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    sl_wait  = 0;
    sl_rdata = 32'h1111_2222;
    m0_req   = {1'b1, make_pay(32'h40, 32'h0, 4'h0)};
    m1_req   = {1'b1, make_pay(32'h80, 32'h5, 4'h1)};
    repeat (2) @(posedge clk);
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", busy); end
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b, want 0", grant); end
    n_cmp++; if (s_req !== '0) begin n_fail++; $display("FAIL reset_s_req: got %h, want 0", s_req); end
    n_cmp++; if ({m0_resp, m1_resp} !== '0) begin
      n_fail++; $display("FAIL reset_resp: got m0=%h m1=%h, want 0", m0_resp, m1_resp);
    end
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || s_req !== '0) begin
        n_fail++; $display("FAIL idle_quiet: got busy=%b s_req=%h, want 0/0", busy, s_req);
      end
    end
  endtask

  task automatic test_single_read();
    logic [PAY_W-1:0] p;
    int busy_n  = 0;
    int rdy_n   = 0;
    int first_s = -1;
    apply_reset();
    sl_wait  = 2;
    sl_rdata = 32'hDEAD_BEEF;
    p = make_pay(32'h100, 32'h0, 4'h0);
    m0_q.push_back(p);
    exp_q.push_back({1'b0, p, 32'hDEAD_BEEF});
    for (int c = 0; c < 8; c++) begin
      tick();
      if (busy) busy_n++;
      if (m0_resp[0]) rdy_n++;
      if (s_req[REQ_W-1] && first_s < 0) first_s = c;
      n_cmp++;
      if (m1_resp !== '0) begin n_fail++; $display("FAIL single_m1_quiet: got %h, want 0", m1_resp); end
    end
    n_cmp++; if (first_s != 1) begin n_fail++; $display("FAIL single_latency: got %0d, want 1", first_s); end
    n_cmp++; if (busy_n != 3) begin n_fail++; $display("FAIL single_busy_len: got %0d, want 3", busy_n); end
    n_cmp++; if (rdy_n != 1) begin n_fail++; $display("FAIL single_ready_cnt: got %0d, want 1", rdy_n); end
    wait_drain(10);
  endtask

  task automatic test_simultaneous();
    logic [PAY_W-1:0] p0;
    logic [PAY_W-1:0] p1;
    logic             first;
    int               gseq[8];
    int               gn = 0;
    int               r0c = -1;
    int               r1c = -1;
    int               rf;
    int               rs;
    apply_reset();
    sl_wait  = 0;
    sl_rdata = 32'hCAFE_F00D;
    p0 = make_pay(32'h200, 32'h0, 4'h0);
    p1 = make_pay(32'h300, 32'h1234_5678, 4'hF);
`ifdef IOB_ARB_ROUND_ROBIN_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    m0_q.push_back(p0);
    m1_q.push_back(p1);
    if (first) begin
      exp_q.push_back({1'b1, p1, 32'hCAFE_F00D});
      exp_q.push_back({1'b0, p0, 32'hCAFE_F00D});
    end else begin
      exp_q.push_back({1'b0, p0, 32'hCAFE_F00D});
      exp_q.push_back({1'b1, p1, 32'hCAFE_F00D});
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (busy && gn < 8) begin gseq[gn] = int'(grant); gn++; end
      if (m0_resp[0] && r0c < 0) r0c = c;
      if (m1_resp[0] && r1c < 0) r1c = c;
    end
    rf = first ? r1c : r0c;
    rs = first ? r0c : r1c;
    n_cmp++; if (gn != 2) begin n_fail++; $display("FAIL simul_grant_cnt: got %0d, want 2", gn); end
    n_cmp++; if (gseq[0] != int'(first)) begin
      n_fail++; $display("FAIL simul_first: got %0d, want %0d", gseq[0], first);
    end
    n_cmp++; if (gseq[1] != int'(!first)) begin
      n_fail++; $display("FAIL simul_second: got %0d, want %0d", gseq[1], !first);
    end
    n_cmp++; if (rf < 0 || rs - rf != 2) begin
      n_fail++; $display("FAIL simul_bubble: got ready cycles %0d,%0d, want gap 2", rf, rs);
    end
    wait_drain(10);
  endtask

  task automatic test_alternate();
    int ord[4];
    int gseq[8];
    int gn = 0;
    int i0 = 0;
    int i1 = 0;
    logic [PAY_W-1:0] p0[2];
    logic [PAY_W-1:0] p1[2];
    apply_reset();
    sl_wait  = 0;
    sl_rdata = 32'h0F0F_1234;
`ifdef IOB_ARB_ROUND_ROBIN_EN
    ord = '{0, 1, 0, 1};
`else
    ord = '{1, 1, 0, 0};
`endif
    for (int k = 0; k < 2; k++) begin
      p0[k] = make_pay(32'h1000 + 32'(k * 4), 32'h0, 4'h0);
      p1[k] = make_pay(32'h2000 + 32'(k * 4), 32'($urandom_range(0, 32'hFFFF)), 4'(k + 1));
      m0_q.push_back(p0[k]);
      m1_q.push_back(p1[k]);
    end
    for (int k = 0; k < 4; k++) begin
      if (ord[k] == 0) begin exp_q.push_back({1'b0, p0[i0], sl_rdata}); i0++; end
      else begin exp_q.push_back({1'b1, p1[i1], sl_rdata}); i1++; end
    end
    for (int c = 0; c < 14; c++) begin
      tick();
      if (busy && gn < 8) begin gseq[gn] = int'(grant); gn++; end
    end
    n_cmp++; if (gn != 4) begin n_fail++; $display("FAIL alt_cnt: got %0d, want 4", gn); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (gseq[k] != ord[k]) begin
        n_fail++; $display("FAIL alt_grant%0d: got %0d, want %0d", k, gseq[k], ord[k]);
      end
    end
    wait_drain(10);
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat = '0;
    int rdy_n = 0;
    logic [PAY_W-1:0] p;
    apply_reset();
    sl_wait  = 0;
    sl_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      p = make_pay(32'h3000 + 32'(k * 8), 32'h7700_0000 + 32'(k), 4'hF);
      m1_q.push_back(p);
      exp_q.push_back({1'b1, p, 32'h5555_AAAA});
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 4) pat[c] = s_req[REQ_W-1];
      if (m1_resp[0]) rdy_n++;
      n_cmp++;
      if (m0_resp !== '0) begin n_fail++; $display("FAIL b2b_m0_quiet: got %h, want 0", m0_resp); end
    end
    n_cmp++; if (pat !== 4'b1010) begin n_fail++; $display("FAIL b2b_pattern: got %b, want 1010", pat); end
    n_cmp++; if (rdy_n != 2) begin n_fail++; $display("FAIL b2b_ready_cnt: got %0d, want 2", rdy_n); end
    wait_drain(10);
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    sl_wait  = 5;
    sl_rdata = 32'h9999_0000;
    m1_q.push_back(make_pay(32'h4000, 32'h0, 4'h0));
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1 || grant !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got busy=%b grant=%b, want 1/1", busy, grant);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (s_req[REQ_W-1] !== 1'b0) begin
      n_fail++; $display("FAIL rmid_s_valid: got %b, want 0", s_req[REQ_W-1]);
    end
    n_cmp++; if (m0_resp[0] !== 1'b0 || m1_resp[0] !== 1'b0) begin
      n_fail++; $display("FAIL rmid_ready: got %b%b, want 00", m0_resp[0], m1_resp[0]);
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, want 0", busy); end
    m1_req = '0;
    m1_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (grant !== 1'b0) begin n_fail++; $display("FAIL rmid_grant: got %b, want 0", grant); end
  endtask

  task automatic test_protocol_violation();
    logic [PAY_W-1:0] p0;
    logic [PAY_W-1:0] p1;
    apply_reset();
    sl_wait  = 5;
    sl_rdata = 32'h0BAD_F00D;
    p0 = make_pay(32'h400, 32'h0, 4'h0);
    p1 = make_pay(32'h500, 32'hA5A5_5A5A, 4'h3);
    m0_q.push_back(p0);
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1 || grant !== 1'b0) begin
      n_fail++; $display("FAIL pv_grant0: got busy=%b grant=%b, want 1/0", busy, grant);
    end
    m1_q.push_back(p1);
    exp_q.push_back({1'b1, p1, 32'h0BAD_F00D});
    tick();
    n_cmp++; if (m1_resp[0] !== 1'b0 || s_req[PAY_W-1:0] !== p0) begin
      n_fail++; $display("FAIL pv_m1_waits: got ready=%b req=%h, want 0 %h", m1_resp[0], s_req[PAY_W-1:0], p0);
    end
    m0_req  = '0;
    sl_wait = 0;
    #1;
    n_cmp++; if (s_req[REQ_W-1] !== 1'b0) begin
      n_fail++; $display("FAIL pv_drop: got %b, want 0", s_req[REQ_W-1]);
    end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pv_idle: got busy=%b, want 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b1 || grant !== 1'b1 || s_req[REQ_W-1] !== 1'b1) begin
      n_fail++; $display("FAIL pv_m1_grant: got busy=%b grant=%b valid=%b, want 1/1/1", busy, grant, s_req[REQ_W-1]);
    end
    wait_drain(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_alternate();
    test_back_to_back();
    test_reset_mid_op();
    test_protocol_violation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
